// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the SAP-2 fetch unit, program memory and the
// execute sequencer. The master side is the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_rd_o;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic [1:0]            instr_len_i;
  logic [DATA_WIDTH-1:0] opcode_o;
  logic [DATA_WIDTH-1:0] temp_1_o;
  logic [DATA_WIDTH-1:0] temp_2_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  instr_valid_o;
  logic                  exec_done_i;
  logic                  pc_load_i;
  logic [ADDR_WIDTH-1:0] pc_load_addr_i;
  logic                  halt_i;
  logic                  halted_o;
  logic                  illegal_len_o;

  modport master (
    output mem_addr_o, mem_rd_o, opcode_o, temp_1_o, temp_2_o, pc_o,
           instr_valid_o, halted_o, illegal_len_o,
    input  mem_data_i, instr_len_i, exec_done_i, pc_load_i,
           pc_load_addr_i, halt_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_o, opcode_o, temp_1_o, temp_2_o, pc_o,
           instr_valid_o, halted_o, illegal_len_o,
    output mem_data_i, instr_len_i, exec_done_i, pc_load_i,
           pc_load_addr_i, halt_i
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// SAP-2 instruction fetch unit: owns the PC, fetches 1-3 byte instructions
// from a 1-cycle-latency memory (4 cycles per byte) and holds the result
// for the execute sequencer until it is retired.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_ADDR, S_WAIT, S_LATCH, S_CHK, S_HOLD, S_HALT
  } state_t;

  state_t                state;
  logic [1:0]            idx;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0] temp_1;
  logic [DATA_WIDTH-1:0] temp_2;
  logic                  rd;
  logic                  valid;
  logic                  halted;
  logic                  illegal;
  logic [1:0]            len_eff;

  // A zero length from decode is fetched as a single-byte instruction.
  assign len_eff = (bus.instr_len_i == 2'd0) ? 2'd1 : bus.instr_len_i;

  assign bus.mem_addr_o    = pc;
  assign bus.mem_rd_o      = rd;
  assign bus.opcode_o      = opcode;
  assign bus.temp_1_o      = temp_1;
  assign bus.temp_2_o      = temp_2;
  assign bus.pc_o          = pc;
  assign bus.instr_valid_o = valid;
  assign bus.halted_o      = halted;
  assign bus.illegal_len_o = illegal;

  // Fetch sequencer: per-byte ADDR/WAIT/LATCH/CHK, then HOLD until retired.
  // Out of reset the FSM sits in S_ADDR with the strobe low; the first edge
  // raises the strobe, every later entry into S_ADDR raises it on the way in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_ADDR;
      idx     <= 2'd0;
      pc      <= RESET_VECTOR;
      opcode  <= '0;
      temp_1  <= '0;
      temp_2  <= '0;
      rd      <= 1'b0;
      valid   <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (rd) state <= S_WAIT;
          else    rd    <= 1'b1;
        end
        S_WAIT: begin
          rd    <= 1'b0;
          state <= S_LATCH;
        end
        S_LATCH: begin
          case (idx)
            2'd0:    opcode <= bus.mem_data_i;
            2'd1:    temp_1 <= bus.mem_data_i;
            default: temp_2 <= bus.mem_data_i;
          endcase
          pc    <= pc + ADDR_WIDTH'(1);
          state <= S_CHK;
        end
        S_CHK: begin
          if (bus.instr_len_i == 2'd0) illegal <= 1'b1;
          if ((idx + 2'd1) < len_eff) begin
            idx   <= idx + 2'd1;
            rd    <= 1'b1;
            state <= S_ADDR;
          end else begin
            idx   <= 2'd0;
            valid <= 1'b1;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.exec_done_i) begin
            valid <= 1'b0;
            if (bus.halt_i) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              if (bus.pc_load_i) pc <= bus.pc_load_addr_i;
              rd    <= 1'b1;
              state <= S_ADDR;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          rd    <= 1'b0;
          valid <= 1'b0;
          idx   <= 2'd0;
          state <= S_ADDR;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the SAP-2 CPU core.
- Fetches 1–3 byte instructions from program memory (synchronous ROM/RAM, 1-cycle read latency) and presents opcode plus operand bytes (temp_1, temp_2) to the control unit's execute sequencer.
- Owns the program counter.
- Holds the fetched instruction behind a valid/done handshake until execute retires it, then fetches the next instruction or a branch target.

Parameters:
- ADDR_WIDTH, 16, program counter / memory address width
- DATA_WIDTH, 8, memory data and instruction byte width
- RESET_VECTOR, 16'hF000, PC value after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- mem_addr_o  out  ADDR_WIDTH  program memory read address
- mem_rd_o  out  1  memory read strobe
- mem_data_i  in  DATA_WIDTH  read data, valid the cycle after mem_rd_o
- instr_len_i  in  2  byte count of opcode_o, driven combinationally by the control-unit decode table from opcode_o
- opcode_o  out  DATA_WIDTH  latched opcode
- temp_1_o  out  DATA_WIDTH  second instruction byte
- temp_2_o  out  DATA_WIDTH  third instruction byte
- pc_o  out  ADDR_WIDTH  program counter (address of next byte to fetch)
- instr_valid_o  out  1  complete instruction held for execute
- exec_done_i  in  1  execute retires the held instruction (1-cycle pulse)
- pc_load_i  in  1  branch taken; sampled only with exec_done_i
- pc_load_addr_i  in  ADDR_WIDTH  branch target
- halt_i  in  1  retire-and-halt; sampled only with exec_done_i
- halted_o  out  1  fetch stopped
- illegal_len_o  out  1  sticky; set when instr_len_i is 0

Behaviour:
- Reset (async, reset==0):
  - pc_o=RESET_VECTOR; opcode_o, temp_1_o, temp_2_o = 0.
  - mem_rd_o, instr_valid_o, halted_o, illegal_len_o = 0.
  - State S_ADDR; byte index = 0.
  - Reset during any state aborts the fetch with no partial latch retained.
  - Release: first rising edge after reset==1 begins S_ADDR.
- Per-byte fetch, exactly 4 cycles:
  - S_ADDR: mem_addr_o=pc_o, mem_rd_o=1.
  - S_WAIT: mem_rd_o=1, address held.
  - S_LATCH: capture mem_data_i into opcode_o, temp_1_o or temp_2_o per byte index; pc_o <= pc_o+1.
  - S_CHK: decide (see below). mem_rd_o=0 in S_LATCH and S_CHK.
- S_CHK decision:
  - Length L = instr_len_i, with L==0 treated as 1 and illegal_len_o set.
  - If bytes fetched < L: byte index++, go to S_ADDR.
  - Else: instr_valid_o=1, go to S_HOLD.
- Operand clearing: on a new opcode latch, temp_1_o/temp_2_o not refilled by that instruction keep their previous values. Execute must not rely on them.
- S_HOLD:
  - instr_valid_o=1; all instruction outputs and pc_o stable.
  - On exec_done_i, with priority halt_i > pc_load_i > sequential:
    - halt_i: instr_valid_o=0, halted_o=1, go to S_HALT.
    - pc_load_i: pc_o <= pc_load_addr_i, instr_valid_o=0, go to S_ADDR.
    - otherwise: instr_valid_o=0, go to S_ADDR with pc_o unchanged.
  - pc_load_i and halt_i are ignored without exec_done_i.
- S_HALT: terminal until reset; outputs frozen, mem_rd_o=0, exec_done_i ignored.
- exec_done_i outside S_HOLD: ignored.
- PC wrap: pc_o increments modulo 2^ADDR_WIDTH (FFFF -> 0000), no flag.
- Latency:
  - L-byte instruction: instr_valid_o asserts 4·L cycles after leaving S_HOLD (or after reset release).
  - Next S_ADDR is the cycle after exec_done_i.

Test Plan:
- Reset, ROM F000=LDI_C,05: after 5 edges from release opcode_o=LDI_C, pc_o=F001; after 4 more temp_1_o=05, pc_o=F002, instr_valid_o=1.
- 1-byte DCR_C at F002 after exec_done_i: opcode_o=DCR_C 4 cycles later, instr_valid_o=1, pc_o=F003; temp_1_o still 05.
- 3-byte JMP F010 with pc_load_i=1, pc_load_addr_i=F010 on exec_done_i: next mem_addr_o=F010, pc_o=F011 after S_LATCH.
- HLT at F003 with halt_i+exec_done_i: halted_o=1, pc_o=F004, mem_rd_o stays 0 for 20 cycles, exec_done_i ignored.
- Opcode at FFFF, instr_len_i=2: operand fetched from 0000, pc_o=0001; instr_len_i=0 -> 1-byte fetch, illegal_len_o=1 until reset.
- Reset pulled low in S_WAIT of byte 2: all outputs reset immediately; refetch from F000 gives identical results to the first scenario.
